pipe_pal_arb: RTL and testbench

PIPE_PAL_ARB -- requirements
Module: pipe_pal_arb

---
 rtl/pipe_pal_pkg.sv | 19 +
 rtl/pipe_pal_arb_if.sv | 30 +++
 rtl/pipe_pal_arb_rr_pick.sv | 32 +++
 rtl/pipe_pal_arb.sv | 130 +++++++++++++
 tb/tb_pipe_pal_arb.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pal_pkg.sv
// Shared types and constants for the pipelined round-robin arbiter with optional burst lock.
package pipe_pal_pkg;

  localparam int DEF_W_DATA = 32;
  localparam int DEF_N_REQ  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_pal_arb_if.sv
// Requester/consumer bundle of pipe_pal_arb; slave modport is the arbiter side.
interface pipe_pal_arb_if
  import pipe_pal_pkg::*;
#(
  parameter int W_DATA = DEF_W_DATA,
  parameter int N_REQ  = DEF_N_REQ
);
  localparam int W_ID = clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*W_DATA-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic [W_DATA-1:0]       out_data;
  logic [W_ID-1:0]         out_id;
  logic                    out_last;
  logic                    out_ready;
  logic                    busy;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_last, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_id, out_last, busy
  );
endinterface

// File: rtl/pipe_pal_arb_rr_pick.sv
// Wrap-around priority search: first set bit of req at or above start, wrapping to 0.
module rr_pick
  import pipe_pal_pkg::*;
#(
  parameter int N    = DEF_N_REQ,
  parameter int W_ID = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [W_ID-1:0] start,
  output logic [N-1:0]    gnt,
  output logic [W_ID-1:0] gnt_id,
  output logic            any
);
  logic [W_ID-1:0] idx;

  // Scan from the lowest priority upward so the last hit is the nearest to start.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W_ID'((int'(start) + k) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pipe_pal_arb.sv
// N-way round-robin arbiter into a single-entry output register.
// Burst locking on req_last is compiled in with PIPE_PAL_ARB_LOCK_EN.
module pipe_pal_arb
  import pipe_pal_pkg::*;
#(
  parameter int W_DATA = DEF_W_DATA,
  parameter int N_REQ  = DEF_N_REQ
) (
  input  logic           i_clk,
  input  logic           resetn,
  pipe_pal_arb_if.slave  bus
);
  localparam int W_ID = clog2(N_REQ);

  arb_state_t        state;
  logic [W_ID-1:0]   rr_ptr;
  logic [W_ID-1:0]   ptr_inc;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  gnt;
  logic [W_ID-1:0]   gnt_id;
  logic              any;
  logic              can_load;
  logic              accept;
  logic              sel_last;
  logic [W_DATA-1:0] sel_data;

  logic              vld_p1;
  logic [W_DATA-1:0] data_p1;
  logic [W_ID-1:0]   id_p1;
  logic              last_p1;

  assign can_load      = !vld_p1 || bus.out_ready;
  assign accept        = can_load && any;
  assign bus.req_ready = accept ? gnt : '0;
  assign ptr_inc       = (gnt_id == W_ID'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

  rr_pick #(.N(N_REQ), .W_ID(W_ID)) u_pick (
    .req    (elig),
    .start  (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_data = bus.req_data[i*W_DATA +: W_DATA];
    end
  end

`ifdef PIPE_PAL_ARB_LOCK_EN
  arb_state_t       state_nxt;
  logic [W_ID-1:0]  lock_id;
  logic [W_ID-1:0]  lock_id_nxt;
  logic [N_REQ-1:0] lock_mask;

  assign lock_mask = {{(N_REQ-1){1'b0}}, 1'b1} << lock_id;
  assign elig      = (state == LOCKED) ? (bus.req_valid & lock_mask) : bus.req_valid;
  assign sel_last  = |(gnt & bus.req_last);

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    case (state)
      IDLE: begin
        if (accept && !sel_last) begin
          state_nxt   = LOCKED;
          lock_id_nxt = gnt_id;
        end
      end
      LOCKED: begin
        if (accept && sel_last) state_nxt = IDLE;
      end
    endcase
  end
`else
  logic unused_last;

  assign state       = IDLE;
  assign elig        = bus.req_valid;
  assign sel_last    = 1'b1;
  assign unused_last = ^bus.req_last;
`endif

  // While locked only lock_id can win, so the pointer moves on the closing beat only.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (accept && ((state == IDLE) || sel_last)) begin
      rr_ptr <= ptr_inc;
    end
  end

  // Stage p1: output register, loaded whenever a beat is accepted
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      last_p1 <= 1'b0;
    end else begin
      if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= sel_data;
        id_p1   <= gnt_id;
        last_p1 <= sel_last;
      end else if (bus.out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_id    = id_p1;
  assign bus.out_last  = last_p1;
  assign bus.busy      = vld_p1 || (state == LOCKED);

endmodule

// File: tb/tb_pipe_pal_arb.sv
// Directed bench for pipe_pal_arb; lock scenarios apply when PIPE_PAL_ARB_LOCK_EN is defined.
module tb_pipe_pal_arb;
  import pipe_pal_pkg::*;

  localparam int W_DATA = 32;
  localparam int N_REQ  = 4;

  logic i_clk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  pipe_pal_arb_if #(.W_DATA(W_DATA), .N_REQ(N_REQ)) bus ();

  pipe_pal_arb #(.W_DATA(W_DATA), .N_REQ(N_REQ)) dut (
    .i_clk  (i_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b1;
    repeat (2) tick();

    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_id",    bus.out_id,    0);
    chk("rst_out_last",  bus.out_last,  0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rr_ptr",    dut.rr_ptr,    0);

    resetn = 1'b1;
    tick();

    // All four requesting: strict rotation starting at requester 0
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*W_DATA +: W_DATA] = 32'h100 + i;
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rot_ready", bus.req_ready, 64'(1 << (k % 4)));
      tick();
      chk("rot_valid", bus.out_valid, 1);
      chk("rot_id",    bus.out_id,    64'(k % 4));
      chk("rot_data",  bus.out_data,  64'(32'h100 + (k % 4)));
      if (k == 7) bus.req_valid = '0;
      #1;
    end
    tick();
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_busy",  bus.busy,      0);

    // Idle: nothing granted, pointer untouched
    for (int k = 0; k < 10; k++) begin
      chk("idle_ready", bus.req_ready, 0);
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_busy",  bus.busy,      0);
      chk("idle_ptr",   dut.rr_ptr,    0);
      tick();
    end

    // Pointer to 2, then 1010 -> 3 wins, then 1 wins
    bus.req_valid = 4'b0010;
    #1;
    chk("p2_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    chk("p2_id", bus.out_id, 1);
    tick();
    chk("p2_ptr", dut.rr_ptr, 2);
    bus.req_valid = 4'b1010;
    #1;
    chk("wrap_ready3", bus.req_ready, 4'b1000);
    tick();
    chk("wrap_id3", bus.out_id, 3);
    #1;
    chk("wrap_ready1", bus.req_ready, 4'b0010);
    tick();
    chk("wrap_id1", bus.out_id, 1);
    bus.req_valid = '0;
    tick();
    chk("wrap_drain", bus.out_valid, 0);

    // Stall: beat from requester 2 held while out_ready is low
    bus.req_data[2*W_DATA +: W_DATA] = 32'hDEADBEEF;
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b0;
    #1;
    chk("stall_accept", bus.req_ready, 4'b0100);
    tick();
    bus.req_data[2*W_DATA +: W_DATA] = 32'hCAFEF00D;
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_data",  bus.out_data,  32'hDEADBEEF);
      chk("stall_id",    bus.out_id,    2);
      chk("stall_ready", bus.req_ready, 0);
      chk("stall_busy",  bus.busy,      1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_ready", bus.req_ready, 4'b1000);
    tick();
    chk("unstall_id",   bus.out_id,   3);
    chk("unstall_data", bus.out_data, 32'h103);
    bus.req_valid = '0;
    tick();
    chk("unstall_drain", bus.out_valid, 0);

    // Single beat from 0 moves the pointer to 1
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b0001;
    #1;
    chk("pre_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    bus.req_last  = '0;
    tick();

`ifdef PIPE_PAL_ARB_LOCK_EN
    // Requester 1 bursts three beats while 0 keeps requesting
    bus.req_valid = 4'b0011;
    #1;
    chk("lock_ready_b0", bus.req_ready, 4'b0010);
    tick();
    chk("lock_id_b0",   bus.out_id,   1);
    chk("lock_last_b0", bus.out_last, 0);
    chk("lock_busy",    bus.busy,     1);
    #1;
    chk("lock_ready_b1", bus.req_ready, 4'b0010);
    tick();
    chk("lock_id_b1", bus.out_id, 1);
    bus.req_last = 4'b0010;
    #1;
    chk("lock_ready_b2", bus.req_ready, 4'b0010);
    tick();
    chk("lock_id_b2",   bus.out_id,   1);
    chk("lock_last_b2", bus.out_last, 1);
    bus.req_valid = 4'b0001;
    bus.req_last  = '0;
    #1;
    chk("unlock_ready", bus.req_ready, 4'b0001);
    tick();
    chk("unlock_id", bus.out_id, 0);
    bus.req_valid = '0;
    tick();
`else
    // Without locking each beat rotates and out_last reads 1
    bus.req_valid = 4'b0011;
    #1;
    chk("nolock_ready1", bus.req_ready, 4'b0010);
    tick();
    chk("nolock_id1",   bus.out_id,   1);
    chk("nolock_last1", bus.out_last, 1);
    #1;
    chk("nolock_ready0", bus.req_ready, 4'b0001);
    tick();
    chk("nolock_id0",   bus.out_id,   0);
    chk("nolock_last0", bus.out_last, 1);
    bus.req_valid = '0;
    tick();
`endif

    // Reset while a beat is held (and, with locking, while LOCKED)
    bus.req_valid = 4'b0010;
    bus.req_last  = '0;
    bus.out_ready = 1'b0;
    tick();
    chk("prerst_valid", bus.out_valid, 1);
    chk("prerst_busy",  bus.busy,      1);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_busy",  bus.busy,      0);
    chk("midrst_data",  bus.out_data,  0);
    chk("midrst_id",    bus.out_id,    0);
    chk("midrst_ptr",   dut.rr_ptr,    0);
    tick();
    resetn        = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0011;
    #1;
    chk("postrst_ready", bus.req_ready, 4'b0001);
    tick();
    chk("postrst_valid", bus.out_valid, 1);
    chk("postrst_id",    bus.out_id,    0);
    chk("postrst_data",  bus.out_data,  32'h100);
    bus.req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
